uart_tx_arbiter: RTL and testbench

Round-robin scheduler that shares the UART transmitter between NUM_REQ byte-stream requesters.
- Acts as a bus master on the UART register port.
- After reset, writes the initial configuration: CTRL = tx enable, then BAUD.
- For each byte: polls STATUS bit[0] (tx busy) and writes TXDATA only when the transmitter is idle.
- Sits between on-chip producers (debug, log, boot messages) and the UART peripheral, replacing ad-hoc software polling.

---
 rtl/uart_pkg.sv | 34 +++
 rtl/rr_arbiter.sv | 40 ++++
 rtl/uart_tx_arbiter.sv | 156 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: register map, bit positions,
// FSM state encoding and the round-robin index helper.
package uart_pkg;

    localparam logic [7:0] UART_CTRL   = 8'h00;
    localparam logic [7:0] UART_STATUS = 8'h04;
    localparam logic [7:0] UART_BAUD   = 8'h08;
    localparam logic [7:0] UART_TXDATA = 8'h0C;

    localparam int CTRL_TX_EN   = 0;
    localparam int CTRL_RX_EN   = 1;
    localparam int CTRL_ID_EN   = 2;
    localparam int STAT_TX_BUSY = 0;
    localparam int STAT_RX_OVER = 1;

    // Transmit only: receive and ID bits stay clear in the init write.
    localparam logic [31:0] CTRL_INIT = (32'd1 << CTRL_TX_EN)
                                      & ~(32'd1 << CTRL_RX_EN)
                                      & ~(32'd1 << CTRL_ID_EN);

    typedef enum logic [5:0] {
        S_INIT_CTRL = 6'b000001,
        S_INIT_BAUD = 6'b000010,
        S_IDLE      = 6'b000100,
        S_POLL      = 6'b001000,
        S_WRITE     = 6'b010000,
        S_SETTLE    = 6'b100000
    } state_e;

    function automatic logic [2:0] rr_wrap_inc(input logic [2:0] idx, input int n);
        return (int'(idx) >= n - 1) ? 3'd0 : idx + 3'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin request selector: picks the first asserted request at or after
// the pointer, wrapping at NUM_REQ.
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [2:0]         ptr_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [2:0]         gnt_idx_o,
    output logic               any_req_o
);

    logic [7:0] req_ext;
    logic [2:0] cand;
    logic       found;

    assign req_ext   = 8'(req_i);
    assign any_req_o = |req_i;

    always_comb begin
        gnt_idx_o = '0;
        found     = 1'b0;
        cand      = ptr_i;
        for (int off = 0; off < NUM_REQ; off++) begin
            if (!found && req_ext[cand]) begin
                found     = 1'b1;
                gnt_idx_o = cand;
            end
            cand = rr_wrap_inc(cand, NUM_REQ);
        end
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_gnt
        assign gnt_o[gi] = en_i && found && (gnt_idx_o == 3'(gi));
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NUM_REQ byte producers: initialises the
// UART, then round-robins requesters and writes each byte once TX is idle.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int          NUM_REQ  = 4,
    parameter logic [31:0] BAUD_DIV = 32'h1B8,
    parameter int          CNT_W    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    input  logic [NUM_REQ*8-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    output logic [2:0]             grant_id_o,
    output logic                   uart_we_o,
    output logic [31:0]            uart_addr_o,
    output logic [31:0]            uart_data_o,
    input  logic [31:0]            uart_data_i,
    output logic                   busy_o,
    output logic [CNT_W-1:0]       tx_count_o
);

    state_e             state_q, state_d;
    logic [2:0]         ptr_q, ptr_d;
    logic [7:0]         byte_q, byte_d;
    logic [2:0]         grant_q, grant_d;
    logic [NUM_REQ-1:0] ready_q, ready_d;
    logic               we_q, we_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        data_q, data_d;
    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               arb_en;
    logic [NUM_REQ-1:0] arb_gnt;
    logic [2:0]         arb_idx;
    logic               arb_any;
    logic [7:0]         req_bytes [8];
    logic               unused_status;

    assign unused_status = ^uart_data_i[31:1];

    for (genvar gi = 0; gi < 8; gi++) begin : g_bytes
        if (gi < NUM_REQ) begin : g_used
            assign req_bytes[gi] = req_data_i[gi*8 +: 8];
        end else begin : g_pad
            assign req_bytes[gi] = 8'h00;
        end
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req_i     (req_valid_i),
        .ptr_i     (ptr_q),
        .en_i      (arb_en),
        .gnt_o     (arb_gnt),
        .gnt_idx_o (arb_idx),
        .any_req_o (arb_any)
    );

    // Bus outputs are registered: each state's action appears on the port in
    // the cycle after the FSM sits in that state.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        byte_d  = byte_q;
        grant_d = grant_q;
        ready_d = '0;
        we_d    = 1'b0;
        addr_d  = {24'h0, UART_STATUS};
        data_d  = '0;
        busy_d  = 1'b1;
        cnt_d   = cnt_q;
        arb_en  = 1'b0;
        case (state_q)
            S_INIT_CTRL: begin
                we_d    = 1'b1;
                addr_d  = {24'h0, UART_CTRL};
                data_d  = CTRL_INIT;
                state_d = S_INIT_BAUD;
            end
            S_INIT_BAUD: begin
                we_d    = 1'b1;
                addr_d  = {24'h0, UART_BAUD};
                data_d  = BAUD_DIV;
                state_d = S_IDLE;
            end
            S_IDLE: begin
                busy_d = 1'b0;
                arb_en = 1'b1;
                if (arb_any) begin
                    byte_d  = req_bytes[arb_idx];
                    grant_d = arb_idx;
                    ready_d = arb_gnt;
                    ptr_d   = rr_wrap_inc(arb_idx, NUM_REQ);
                    state_d = S_POLL;
                end
            end
            S_POLL: begin
                if (!uart_data_i[STAT_TX_BUSY]) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                we_d    = 1'b1;
                addr_d  = {24'h0, UART_TXDATA};
                data_d  = {24'h0, byte_q};
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_INIT_CTRL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_INIT_CTRL;
            ptr_q   <= '0;
            byte_q  <= '0;
            grant_q <= '0;
            ready_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            byte_q  <= byte_d;
            grant_q <= grant_d;
            ready_q <= ready_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
        end
    end

    assign req_ready_o = ready_q;
    assign grant_id_o  = grant_q;
    assign uart_we_o   = we_q;
    assign uart_addr_o = addr_q;
    assign uart_data_o = data_q;
    assign busy_o      = busy_q;
    assign tx_count_o  = cnt_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: UART register model, TXDATA scoreboard, a table of
// single-byte arbitration vectors and hand-written multi-cycle sequences.
module tb_uart_tx_arbiter;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic [2:0]  grant_id;
    logic        uart_we;
    logic [31:0] uart_addr;
    logic [31:0] uart_wdata;
    logic [31:0] uart_rdata;
    logic        busy;
    logic [15:0] tx_count;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ  (4),
        .BAUD_DIV (32'h1B8),
        .CNT_W    (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_ready_o (req_ready),
        .grant_id_o  (grant_id),
        .uart_we_o   (uart_we),
        .uart_addr_o (uart_addr),
        .uart_data_o (uart_wdata),
        .uart_data_i (uart_rdata),
        .busy_o      (busy),
        .tx_count_o  (tx_count)
    );

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_wr = 0;
    int last_wr_cyc = 0;
    int ready_pulses = 0;
    int busy_cnt = 0;
    int busy_len = 3;
    int exp_cnt = 0;
    logic force_busy = 1'b0;
    logic uart_status;
    logic status_prev = 1'b0;
    logic [7:0] mon_exp;
    logic [7:0] sb [$];

    typedef struct {
        logic [3:0] mask;
        logic [7:0] base;
        int         grant;
        logic [7:0] exp_byte;
    } vec_t;
    vec_t tab [8];

    // UART model: TX stays busy for busy_len cycles after each TXDATA write.
    assign uart_status = force_busy || (busy_cnt != 0);
    assign uart_rdata  = (uart_addr == 32'h4) ? {31'h0, uart_status} : 32'h0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) busy_cnt <= 0;
        else if (uart_we && uart_addr == 32'hC) busy_cnt <= busy_len;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && uart_we) begin
            chk("write_addr_legal",
                {31'h0, (uart_addr == 32'h0 || uart_addr == 32'h8 || uart_addr == 32'hC)}, 32'h1);
            if (uart_addr == 32'hC) begin
                n_wr++;
                last_wr_cyc = cyc;
                chk("tx_only_when_idle", {31'h0, status_prev}, 32'h0);
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL txdata_unexpected: actual %h required no write", uart_wdata);
                end else begin
                    mon_exp = sb.pop_front();
                    chk("txdata", uart_wdata, {24'h0, mon_exp});
                end
                $display("[TB] cycle %0d TXDATA write 0x%02h tx_count=%0d", cyc, uart_wdata[7:0], tx_count);
            end
        end
        if (req_ready != 4'b0) ready_pulses++;
        status_prev = uart_status;
    end

    task automatic wait_ready(input int limit, output int idx, output int at_cyc);
        idx = -1;
        at_cyc = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (req_ready != 4'b0) begin
                chk("ready_onehot", {31'h0, $onehot(req_ready)}, 32'h1);
                for (int b = 0; b < N; b++) if (req_ready[b]) idx = b;
                at_cyc = cyc;
                $display("[TB] cycle %0d accept requester %0d", cyc, idx);
                return;
            end
        end
        chk("ready_timeout", 32'h0, 32'h1);
    endtask

    task automatic wait_writes(input int target, input int limit);
        for (int i = 0; i < limit && n_wr < target; i++) @(negedge clk);
        chk("write_count", n_wr, target);
    endtask

    task automatic check_reset_outputs();
        chk("rst_we", {31'h0, uart_we}, 32'h0);
        chk("rst_addr", uart_addr, 32'h0);
        chk("rst_data", uart_wdata, 32'h0);
        chk("rst_ready", {28'h0, req_ready}, 32'h0);
        chk("rst_grant", {29'h0, grant_id}, 32'h0);
        chk("rst_count", {16'h0, tx_count}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h1);
    endtask

    // Called at the negedge where rst has just been released.
    task automatic check_init();
        @(negedge clk);
        chk("init1_we", {31'h0, uart_we}, 32'h1);
        chk("init1_addr", uart_addr, 32'h0);
        chk("init1_data", uart_wdata, 32'h1);
        @(negedge clk);
        chk("init2_we", {31'h0, uart_we}, 32'h1);
        chk("init2_addr", uart_addr, 32'h8);
        chk("init2_data", uart_wdata, 32'h1B8);
        @(negedge clk);
        chk("init3_busy", {31'h0, busy}, 32'h0);
        chk("init3_we", {31'h0, uart_we}, 32'h0);
        chk("init3_addr", uart_addr, 32'h4);
    endtask

    initial begin
        int g, kc, w0, p0;
        tab[0] = '{4'b0001, 8'h41, 0, 8'h41};
        tab[1] = '{4'b0001, 8'h50, 0, 8'h50};
        tab[2] = '{4'b1001, 8'h60, 3, 8'h63};
        tab[3] = '{4'b0110, 8'h70, 1, 8'h71};
        tab[4] = '{4'b0111, 8'h80, 2, 8'h82};
        tab[5] = '{4'b1111, 8'h90, 3, 8'h93};
        tab[6] = '{4'b0100, 8'hA0, 2, 8'hA2};
        tab[7] = '{4'b0011, 8'hB0, 0, 8'hB0};

        rst = 1'b1;
        req_valid = 4'b0;
        req_data = 32'h0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;
        check_init();

        busy_len = 3;
        for (int e = 0; e < 8; e++) begin
            req_valid = tab[e].mask;
            for (int i = 0; i < N; i++) req_data[i*8 +: 8] = tab[e].base + 8'(i);
            sb.push_back(tab[e].exp_byte);
            exp_cnt++;
            w0 = n_wr;
            wait_ready(50, g, kc);
            req_valid = 4'b0;
            chk("vec_grant", g, tab[e].grant);
            chk("vec_grant_id", {29'h0, grant_id}, tab[e].grant);
            wait_writes(w0 + 1, 50);
            chk("vec_latency", last_wr_cyc - kc, 2);
            chk("vec_tx_count", {16'h0, tx_count}, exp_cnt);
            repeat (15) @(negedge clk);
        end

        // All four requesters at once, slow UART; pointer restarts at 0 after reset.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sb.delete();
        exp_cnt = 0;
        check_init();
        busy_len = 10;
        req_data = 32'h33323130;
        req_valid = 4'hF;
        for (int i = 0; i < N; i++) sb.push_back(8'h30 + 8'(i));
        w0 = n_wr;
        for (int n = 0; n < N; n++) begin
            wait_ready(200, g, kc);
            chk("rr_all_grant", g, n);
            if (g >= 0 && g < N) req_valid[g] = 1'b0;
        end
        wait_writes(w0 + 4, 200);
        exp_cnt = 4;
        chk("rr_all_count", {16'h0, tx_count}, exp_cnt);
        repeat (15) @(negedge clk);

        // Requesters 1 and 3 streaming three bytes each must alternate.
        req_data = 32'h70005000;
        req_valid = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            sb.push_back(8'h50 + 8'(i));
            sb.push_back(8'h70 + 8'(i));
        end
        w0 = n_wr;
        for (int n = 0; n < 6; n++) begin
            wait_ready(200, g, kc);
            chk("alt_grant", g, (n % 2 == 0) ? 1 : 3);
            if (g == 1) req_data[15:8] = req_data[15:8] + 8'd1;
            if (g == 3) req_data[31:24] = req_data[31:24] + 8'd1;
            if (n == 4) req_valid[1] = 1'b0;
            if (n == 5) req_valid[3] = 1'b0;
        end
        wait_writes(w0 + 6, 300);
        exp_cnt = 10;
        chk("alt_count", {16'h0, tx_count}, exp_cnt);
        repeat (15) @(negedge clk);

        // TX busy held for 500 cycles: no write until it clears.
        force_busy = 1'b1;
        req_data[7:0] = 8'h99;
        req_valid = 4'b0001;
        sb.push_back(8'h99);
        w0 = n_wr;
        wait_ready(100, g, kc);
        req_valid = 4'b0;
        chk("hold_grant", g, 0);
        repeat (500) @(negedge clk);
        chk("hold_no_write", n_wr, w0);
        chk("hold_busy", {31'h0, busy}, 32'h1);
        chk("hold_poll_addr", uart_addr, 32'h4);
        force_busy = 1'b0;
        // The next edge samples STATUS[0]=0; the write shows in the cycle after.
        @(negedge clk);
        chk("release_no_write_yet", {31'h0, uart_we}, 32'h0);
        @(negedge clk);
        chk("release_we", {31'h0, uart_we}, 32'h1);
        chk("release_addr", uart_addr, 32'hC);
        chk("release_data", uart_wdata, 32'h99);
        exp_cnt = 11;
        @(negedge clk);
        chk("release_count", {16'h0, tx_count}, exp_cnt);
        repeat (15) @(negedge clk);

        // Reset while polling: pending byte is dropped and never acknowledged again.
        force_busy = 1'b1;
        req_data[23:16] = 8'hEE;
        req_valid = 4'b0100;
        wait_ready(100, g, kc);
        req_valid = 4'b0;
        chk("rstpoll_grant", g, 2);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs();
        force_busy = 1'b0;
        rst = 1'b0;
        p0 = ready_pulses;
        w0 = n_wr;
        check_init();
        repeat (30) @(negedge clk);
        chk("rstpoll_no_reack", ready_pulses - p0, 0);
        chk("rstpoll_no_write", n_wr, w0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

endmodule
